// File: rtl/mem_pkg.sv
// Shared types and constants for the CPU data-memory responder.
// Read-state encoding, bus widths and default stack bases.
package mem_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 8;

    localparam logic [ADDR_W-1:0] OP_STACK_BASE   = 32'h0000_00AA;
    localparam logic [ADDR_W-1:0] CALL_STACK_BASE = 32'h0000_0055;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2,
        GAP   = 2'd3
    } rd_state_e;

    // True when a byte address falls inside an array of the given depth.
    function automatic logic in_range(
        input logic [ADDR_W-1:0] a,
        input int unsigned       depth
    );
        return (a < depth);
    endfunction

endpackage

// File: rtl/byte_ram.sv
// Byte array with one write port and a read port driven by a held address.
// Contents are not reset; the image is preloaded through the init port.
module byte_ram
    import mem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Commit at most one byte per edge.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Pre-edge contents, so a same-edge write is not seen by the reader.
    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mem_responder.sv
// Memory-bus responder: fixed-latency reads with a one-cycle ready pulse,
// single-cycle writes, a preload port and a sticky out-of-range flag.
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH        = 256,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    input  logic              memory_read_en,
    input  logic              memory_write_en,
    output logic              memory_ready,
    input  logic              init_en,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [DATA_W-1:0] init_data,
    output logic              oob_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] CNT_LOAD = 4'(READ_LATENCY - 1);

    rd_state_e         r_state;
    rd_state_e         w_state_nxt;
    logic [3:0]        r_cnt;
    logic [3:0]        w_cnt_nxt;
    logic [ADDR_W-1:0] r_req_addr;
    logic [ADDR_W-1:0] w_req_nxt;
    logic [ADDR_W-1:0] w_rd_addr;
    logic              w_rd_req;
    logic              w_load;
    logic              w_rd_ok;
    logic [DATA_W-1:0] w_rd_data;
    logic [DATA_W-1:0] r_data_out;
    logic              r_oob;

    logic              w_we;
    logic              w_wr_oob;
    logic [AW-1:0]     w_waddr;
    logic [DATA_W-1:0] w_wdata;

    // Read FSM state, down-counter and latched request address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= 4'd0;
            r_req_addr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_req_addr <= w_req_nxt;
        end
    end

    // Next state; w_load marks the edge that enters READY and loads data.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_req_nxt   = r_req_addr;
        w_load      = 1'b0;
        w_rd_req    = 1'b0;
        // X or Z from a halted initiator falls through as not-asserted.
        if (memory_read_en == 1'b1) begin
            w_rd_req = 1'b1;
        end
        unique case (r_state)
            IDLE: begin
                if (w_rd_req) begin
                    w_req_nxt = addr;
                    if (READ_LATENCY <= 1) begin
                        w_state_nxt = READY;
                        w_load      = 1'b1;
                    end else begin
                        w_cnt_nxt   = CNT_LOAD;
                        w_state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state_nxt = READY;
                    w_load      = 1'b1;
                end
            end
            READY: w_state_nxt = GAP;
            GAP:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // With latency 1 the byte is fetched on the accepting edge itself.
    assign w_rd_addr = (r_state == IDLE) ? addr : r_req_addr;
    assign w_rd_ok   = in_range(w_rd_addr, DEPTH);

    // Init port has priority; a losing bus write is dropped silently.
    always_comb begin
        w_we     = 1'b0;
        w_wr_oob = 1'b0;
        w_waddr  = addr[AW-1:0];
        w_wdata  = data_in;
        if (init_en == 1'b1) begin
            w_waddr = init_addr[AW-1:0];
            w_wdata = init_data;
            if (in_range(init_addr, DEPTH)) begin
                w_we = 1'b1;
            end else begin
                w_wr_oob = 1'b1;
            end
        end else if (memory_write_en == 1'b1) begin
            if (in_range(addr, DEPTH)) begin
                w_we = 1'b1;
            end else begin
                w_wr_oob = 1'b1;
            end
        end
    end

    byte_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (w_rd_addr[AW-1:0]),
        .o_rdata (w_rd_data)
    );

    // Read data holds until the next READY; oob flag is sticky.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_out <= '0;
            r_oob      <= 1'b0;
        end else begin
            if (w_load) begin
                r_data_out <= w_rd_ok ? w_rd_data : '0;
            end
            if ((w_load && !w_rd_ok) || w_wr_oob) begin
                r_oob <= 1'b1;
            end
        end
    end

    assign data_out     = r_data_out;
    assign oob_err      = r_oob;
    assign memory_ready = (r_state == READY);

endmodule

// File: tb/tb_mem_responder.sv
// Directed and randomized bench for mem_responder at READ_LATENCY=3.
// Expected data comes from a byte-array model of the memory contents.
module tb_mem_responder;
    import mem_pkg::*;

    localparam int LAT   = 3;
    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        memory_read_en;
    logic        memory_write_en;
    logic        memory_ready;
    logic        init_en;
    logic [31:0] init_addr;
    logic [7:0]  init_data;
    logic        oob_err;

    int checks   = 0;
    int failures = 0;

    logic [7:0] ref_mem [DEPTH];
    bit         ref_ok  [DEPTH];
    bit         ref_oob;

    mem_responder #(
        .DEPTH        (DEPTH),
        .READ_LATENCY (LAT)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .addr            (addr),
        .data_in         (data_in),
        .data_out        (data_out),
        .memory_read_en  (memory_read_en),
        .memory_write_en (memory_write_en),
        .memory_ready    (memory_ready),
        .init_en         (init_en),
        .init_addr       (init_addr),
        .init_data       (init_data),
        .oob_err         (oob_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mwrite(input logic [31:0] a, input logic [7:0] d,
                          input bit via_init);
        @(negedge clk);
        if (via_init) begin
            init_en   = 1'b1;
            init_addr = a;
            init_data = d;
        end else begin
            memory_write_en = 1'b1;
            addr            = a;
            data_in         = d;
        end
        @(negedge clk);
        init_en         = 1'b0;
        memory_write_en = 1'b0;
        if (a < DEPTH) begin
            ref_mem[a[7:0]] = d;
            ref_ok[a[7:0]]  = 1'b1;
        end else begin
            ref_oob = 1'b1;
        end
    endtask

    // Single read: ready must rise exactly LAT cycles after acceptance.
    task automatic mread(input logic [31:0] a, input string tag);
        logic [7:0] exp;
        exp = (a < DEPTH) ? ref_mem[a[7:0]] : 8'h00;
        @(negedge clk);
        addr           = a;
        memory_read_en = 1'b1;
        @(negedge clk);
        memory_read_en = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            if (k > 1) @(negedge clk);
            chk({tag, "_rdy"}, 32'(memory_ready), 32'(k == LAT));
        end
        chk({tag, "_data"}, 32'(data_out), 32'(exp));
        if (a >= DEPTH) ref_oob = 1'b1;
        chk({tag, "_oob"}, 32'(oob_err), 32'(ref_oob));
        @(negedge clk);
        chk({tag, "_gap"}, 32'(memory_ready), 32'd0);
        chk({tag, "_hold"}, 32'(data_out), 32'(exp));
    endtask

    initial begin
        rst_n           = 1'b0;
        addr            = '0;
        data_in         = '0;
        memory_read_en  = 1'b0;
        memory_write_en = 1'b0;
        init_en         = 1'b0;
        init_addr       = '0;
        init_data       = '0;
        ref_oob         = 1'b0;
        #1;
        chk("rst_ready", 32'(memory_ready), 32'd0);
        chk("rst_data", 32'(data_out), 32'd0);
        chk("rst_oob", 32'(oob_err), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        mwrite(32'h10, 8'h41, 1'b1);
        mwrite(32'h11, 8'h05, 1'b1);
        mwrite(32'h20, 8'h7F, 1'b1);
        mwrite(32'h00, 8'h99, 1'b1);

        // Held read_en: address moves during GAP, pulses LAT+2 apart.
        @(negedge clk);
        addr           = 32'h10;
        memory_read_en = 1'b1;
        for (int k = 1; k <= 2 * LAT + 3; k++) begin
            @(negedge clk);
            chk("b2b_rdy", 32'(memory_ready),
                32'((k == LAT) || (k == 2 * LAT + 2)));
            if (k == LAT) chk("b2b_d0", 32'(data_out), 32'h41);
            if (k == LAT + 1) addr = 32'h11;
            if (k == 2 * LAT + 2) begin
                chk("b2b_d1", 32'(data_out), 32'h05);
                memory_read_en = 1'b0;
            end
        end

        mread(32'h20, "lat");

        mwrite(OP_STACK_BASE, 8'hAB, 1'b0);
        mread(OP_STACK_BASE, "wr_rd");

        // Write lands on the same edge that loads data_out: old byte.
        @(negedge clk);
        addr           = OP_STACK_BASE;
        memory_read_en = 1'b1;
        @(negedge clk);
        memory_read_en = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            if (k > 1) @(negedge clk);
            chk("rbw_rdy", 32'(memory_ready), 32'(k == LAT));
            if (k == LAT - 1) begin
                memory_write_en = 1'b1;
                addr            = OP_STACK_BASE;
                data_in         = 8'hCD;
            end
            if (k == LAT) begin
                memory_write_en = 1'b0;
                chk("rbw_old", 32'(data_out), 32'hAB);
            end
        end
        ref_mem[8'hAA] = 8'hCD;
        @(negedge clk);
        mread(OP_STACK_BASE, "rbw_new");

        // Same-edge init and bus write: init wins, no flag for the loser.
        @(negedge clk);
        init_en         = 1'b1;
        init_addr       = 32'h30;
        init_data       = 8'h11;
        memory_write_en = 1'b1;
        addr            = 32'h30;
        data_in         = 8'h22;
        @(negedge clk);
        init_addr = 32'h31;
        init_data = 8'h33;
        addr      = 32'h300;
        @(negedge clk);
        init_en         = 1'b0;
        memory_write_en = 1'b0;
        ref_mem[8'h30]  = 8'h11;
        ref_mem[8'h31]  = 8'h33;
        ref_ok[8'h30]   = 1'b1;
        ref_ok[8'h31]   = 1'b1;
        chk("coll_oob", 32'(oob_err), 32'd0);
        mread(32'h30, "coll");
        mread(32'h31, "coll2");

        mread(32'h100, "oob_rd");
        mwrite(32'h200, 8'h77, 1'b0);
        chk("oob_sticky", 32'(oob_err), 32'd1);
        mread(32'h00, "oob_wr");

        // Reset during WAIT abandons the read.
        mread(32'h10, "pre_rst");
        @(negedge clk);
        addr           = 32'h20;
        memory_read_en = 1'b1;
        @(negedge clk);
        memory_read_en = 1'b0;
        rst_n          = 1'b0;
        ref_oob        = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(memory_ready), 32'd0);
        chk("mid_rst_data", 32'(data_out), 32'd0);
        chk("mid_rst_oob", 32'(oob_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 2 * LAT + 2; k++) begin
            @(negedge clk);
            chk("no_late_rdy", 32'(memory_ready), 32'd0);
        end
        mread(32'h20, "post_rst");

        for (int i = 0; i < 40; i++) begin
            int unsigned op;
            logic [31:0] a;
            op = $urandom_range(0, 3);
            if (op < 2) begin
                if ($urandom_range(0, 7) == 0) a = 32'h100 + $urandom_range(0, 4095);
                else a = 32'($urandom_range(0, DEPTH - 1));
                mwrite(a, 8'($urandom), op == 1);
                chk("rnd_wr_oob", 32'(oob_err), 32'(ref_oob));
            end else begin
                a = 32'($urandom_range(0, DEPTH - 1));
                if (!ref_ok[a[7:0]]) mwrite(a, 8'($urandom), 1'b0);
                mread(a, "rnd");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
